// File: rtl/gf571_pkg.sv
// Shared constants and types for the GF(2)[x] 571-bit sequenced multiplier.
package gf571_pkg;
    localparam int OP_W   = 571;
    localparam int LIMB_W = 143;
    localparam int NLIMB  = 4;
    localparam int PAD_W  = 572;
    localparam int PROD_W = 1141;
    localparam int ACC_W  = 1144;
    localparam int PP_W   = 2 * LIMB_W;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    typedef logic [2:0] off_t;
endpackage

// File: rtl/gf571_mul_seq_if.sv
// Request/response bundle between point-arithmetic control and gf571_mul_seq.
interface gf571_mul_seq_if;
    logic                        start;
    logic                        square;
    logic [gf571_pkg::OP_W-1:0]  a;
    logic [gf571_pkg::OP_W-1:0]  b;
    logic                        busy;
    logic                        done;
    logic [gf571_pkg::PROD_W-1:0] d;

    modport master (output start, square, a, b, input busy, done, d);
    modport slave  (input start, square, a, b, output busy, done, d);
endinterface

// File: rtl/gf571_mul_seq_mult143.sv
// 143x143 carry-less multiplier with a LAT-deep output pipeline.
module mult143
    import gf571_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic              i_clk,
    input  logic [LIMB_W-1:0] i_a,
    input  logic [LIMB_W-1:0] i_b,
    output logic [PP_W-1:0]   o_p
);
    logic [PP_W-1:0] w_p;
    logic [PP_W-1:0] r_pipe [LAT];

    always_comb begin
        w_p = '0;
        for (int i = 0; i < LIMB_W; i++) begin
            if (i_b[i]) w_p = w_p ^ (PP_W'(i_a) << i);
        end
    end

    always_ff @(posedge i_clk) begin
        r_pipe[0] <= w_p;
        for (int s = 1; s < LAT; s++) r_pipe[s] <= r_pipe[s-1];
    end

    assign o_p = r_pipe[LAT-1];
endmodule

// File: rtl/gf571_mul_seq.sv
// Unreduced 571x571 GF(2)[x] product by time-sharing one 143x143 core.
// Optional squaring shortcut (diagonal limb pairs only): GF571_MUL_SQUARE_EN.
module gf571_mul_seq
    import gf571_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input logic            i_clk,
    input logic            i_rst,
    gf571_mul_seq_if.slave bus
);
    localparam logic [MUL_LAT-1:0] TAG_OUT = MUL_LAT'(1) << (MUL_LAT - 1);

    state_t                         r_state;
    logic [NLIMB-1:0][LIMB_W-1:0]   r_a, r_b;
    logic [3:0]                     r_idx;
    logic                           r_busy, r_done;
    logic [MUL_LAT-1:0]             r_tag_vld;
    off_t                           r_tag_off [MUL_LAT];
    logic [ACC_W-1:0]               r_acc;

    logic                 w_sq, w_issue, w_last, w_pend;
    logic [1:0]           w_i, w_j;
    off_t                 w_off;
    logic [LIMB_W-1:0]    w_op_a, w_op_b;
    logic [PP_W-1:0]      w_p;
    logic [ACC_W-1:0]     w_p_sh;
    logic [ACC_W-PROD_W-1:0] w_unused_acc_hi;

`ifdef GF571_MUL_SQUARE_EN
    logic r_sq;
    assign w_sq = r_sq;
`else
    logic w_unused_sq;
    assign w_unused_sq = bus.square;
    assign w_sq        = 1'b0;
`endif

    // Squaring walks only the diagonal, so both limb indices follow idx[1:0].
    assign w_i     = w_sq ? r_idx[1:0] : r_idx[3:2];
    assign w_j     = r_idx[1:0];
    assign w_issue = (r_state == ISSUE);
    assign w_last  = w_sq ? (r_idx == 4'd3) : (r_idx == 4'd15);
    assign w_off   = off_t'(w_i) + off_t'(w_j);
    assign w_op_a  = r_a[w_i];
    assign w_op_b  = w_sq ? w_op_a : r_b[w_j];
    // Anything still in flight ahead of the core output stage.
    assign w_pend  = |(r_tag_vld & ~TAG_OUT);
    assign w_p_sh  = ACC_W'(w_p) << (LIMB_W * r_tag_off[MUL_LAT-1]);

    mult143 #(.LAT(MUL_LAT)) u_core (
        .i_clk (i_clk),
        .i_a   (w_op_a),
        .i_b   (w_op_b),
        .o_p   (w_p)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_acc     <= '0;
            r_tag_vld <= '0;
            r_idx     <= '0;
        end else begin
            r_done       <= 1'b0;
            r_tag_vld[0] <= w_issue;
            r_tag_off[0] <= w_off;
            for (int s = 1; s < MUL_LAT; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_off[s] <= r_tag_off[s-1];
            end
            if (r_tag_vld[MUL_LAT-1]) r_acc <= r_acc ^ w_p_sh;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= {1'b0, bus.a};
                        r_b     <= {1'b0, bus.b};
`ifdef GF571_MUL_SQUARE_EN
                        r_sq    <= bus.square;
`endif
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_idx <= r_idx + 4'd1;
                    if (w_last) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (!w_pend) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.d           = r_acc[PROD_W-1:0];
    assign w_unused_acc_hi = r_acc[ACC_W-1:PROD_W];
endmodule

// File: tb/tb_gf571_mul_seq.sv
// Scoreboard bench for gf571_mul_seq against a bitwise carry-less multiply model.
module tb_gf571_mul_seq;
    import gf571_pkg::*;

    localparam int LAT = 2;
`ifdef GF571_MUL_SQUARE_EN
    localparam bit SQ_EN = 1'b1;
`else
    localparam bit SQ_EN = 1'b0;
`endif

    typedef struct {
        logic [PROD_W-1:0] d;
        int                cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    gf571_mul_seq_if bus ();

    gf571_mul_seq #(.MUL_LAT(LAT)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PROD_W-1:0] clmul(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y);
        logic [PROD_W-1:0] r;
        r = '0;
        for (int i = 0; i < OP_W; i++)
            if (x[i]) r = r ^ (PROD_W'(y) << i);
        return r;
    endfunction

    function automatic logic [OP_W-1:0] rnd_op();
        logic [575:0] t;
        for (int w = 0; w < 18; w++) t[w*32 +: 32] = $urandom;
        return t[OP_W-1:0];
    endfunction

    task automatic chk_w(input string nm, input logic [PROD_W-1:0] act, input logic [PROD_W-1:0] exp);
        int fd;
        checks++;
        if (act !== exp) begin
            errors++;
            fd = -1;
            for (int i = PROD_W - 1; i >= 0; i--) if (act[i] !== exp[i]) fd = i;
            $display("FAIL %s act_lo=%h exp_lo=%h first_diff_bit=%0d", nm, act[255:0], exp[255:0], fd);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    // Monitor: every done pops one expectation (value and arrival cycle).
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done cyc=%0d act=1 exp=0", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk_w("d", bus.d, e.d);
                chk_i("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Called just after a rising edge; that cycle is cycle 0 of the new operation.
    task automatic start_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                            input logic sq, input logic [PROD_W-1:0] exp);
        exp_t e;
        int   n;
        n     = (SQ_EN && sq) ? 4 : 16;
        e.d   = exp;
        e.cyc = cyc + n + LAT + 1;
        sb.push_back(e);
        bus.start  = 1'b1;
        bus.a      = a;
        bus.b      = b;
        bus.square = sq;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    bit aborted = 1'b0;

    // Returns in the done cycle so the caller can start back-to-back.
    task automatic run_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                          input logic sq, input logic [PROD_W-1:0] exp);
        int n, bcnt;
        bit seen;
        n    = (SQ_EN && sq) ? 4 : 16;
        bcnt = 0;
        seen = 1'b0;
        start_op(a, b, sq, exp);
        for (int k = 0; k < 100; k++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy === 1'b1) bcnt++;
            @(posedge clk);
            #1;
        end
        if (!seen) begin
            checks++;
            errors++;
            aborted = 1'b1;
            $display("FAIL done_timeout act=none exp=done_within_100");
            return;
        end
        chk_i("busy_cycles", bcnt, n + LAT);
        chk_i("busy_at_done", int'(bus.busy), 0);
    endtask

    initial begin
        logic [OP_W-1:0]   ta, tb2;
        logic [PROD_W-1:0] te;
        logic              sq;

        bus.start  = 1'b0;
        bus.square = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_i("rst_busy", int'(bus.busy), 0);
        chk_i("rst_done", int'(bus.done), 0);
        chk_w("rst_d", bus.d, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        ta = '0; ta[0] = 1'b1;
        te = '0; te[0] = 1'b1;
        run_op(ta, ta, 1'b0, te);

        ta = '0; ta[570] = 1'b1;
        te = '0; te[1140] = 1'b1;
        run_op(ta, ta, 1'b0, te);

        ta = '1;
        tb2 = '0; tb2[143] = 1'b1;
        te = PROD_W'(ta) << 143;
        run_op(ta, tb2, 1'b0, te);

        ta = '0; ta[300] = 1'b1; ta[1] = 1'b1; ta[0] = 1'b1;
        te = '0; te[600] = 1'b1; te[2] = 1'b1; te[0] = 1'b1;
        run_op(ta, ta, 1'b1, te);

        // Reset in cycle 8 of an operation: nothing may survive it.
        ta = rnd_op();
        tb2 = rnd_op();
        start_op(ta, tb2, 1'b0, clmul(ta, tb2));
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_i("midrst_busy", int'(bus.busy), 0);
        chk_i("midrst_done", int'(bus.done), 0);
        chk_w("midrst_d", bus.d, '0);
        sb.delete();
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        ta = '0; ta[1] = 1'b1; ta[0] = 1'b1;
        te = '0; te[2] = 1'b1; te[0] = 1'b1;
        run_op(ta, ta, 1'b0, te);

        for (int k = 0; k < 1000 && !aborted; k++) begin
            ta  = rnd_op();
            tb2 = rnd_op();
            sq  = 1'($urandom_range(0, 1));
            run_op(ta, tb2, sq, clmul(ta, (SQ_EN && sq) ? ta : tb2));
        end

        repeat (4) @(posedge clk);
        #1;
        chk_i("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/gf571_mul_seq.md
# gf571_mul_seq

Sequencer that computes the unreduced GF(2)[x] product of two 571-bit operands by time-sharing a single 143×143 carry-less multiplier core. Operands are split into four 143-bit limbs, giving a 572-bit padded width. Limb pairs are issued one per cycle into the pipelined core, and the 286-bit partial products are XOR-accumulated at limb offsets. The block sits between the point-arithmetic control and the GF(2^571) reduction stage, which consumes `d`.

## Interface
- `MUL_LAT`, default 2: pipeline depth of the instantiated core, in cycles from operand issue to product valid. Legal range 1..8.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; `a`, `b` and `square` are sampled in the same cycle when accepted.
- `square`  in  1  operands are equal (a squaring); behaviour depends on `GF571_MUL_SQUARE_EN`.
- `a`  in  571  operand A, bit i is the coefficient of x^i.
- `b`  in  571  operand B.
- `busy`  out  1  high from the cycle after acceptance until the `done` cycle (exclusive).
- `done`  out  1  one-cycle pulse; `d` is valid from this cycle on.
- `d`  out  1141  product, coefficients x^0..x^1140; held until the next accepted `start`.

## Operation
- Limbs: A_k = a_pad[143k+142 : 143k] for k = 0..3, with a_pad = {1'b0, a}. B_k is formed the same way from `b`.
- States:
  - IDLE: `start`=1 latches the operands, clears the 1144-bit accumulator, clears the issue index and moves to ISSUE.
  - ISSUE: issues one pair (A_i, B_j) per cycle in i-major order (0,0),(0,1)…(3,3). After the last pair it moves to DRAIN.
  - DRAIN: waits until the in-flight tag pipe is empty, then moves to IDLE and pulses `done`.
- Tag pipe: MUL_LAT stages. Each stage holds a valid bit and a 3-bit offset k = i+j (range 0..6). It runs in lockstep with the core.
- Accumulate: when the tag at the core output is valid, acc ^= P << (143·k), where P is 286 bits. The maximum shifted extent is bit 1143.
- Output: `d` = acc[1140:0]. Bits 1141..1143 are always zero for 571-bit inputs.
- `start` is ignored while `busy`=1, and is also ignored in any cycle where `rst`=1.
- `start` in the same cycle as `done` is accepted, so back-to-back operations have no bubble.
- Reset values: state IDLE, `busy`=0, `done`=0, acc=0 (so `d`=0), all tag valids 0.
- Reset mid-operation:
  - In-flight products are discarded and no `done` is produced.
  - The next `start` after reset produces a correct result.

## Timing
- Cycle 0: `start` is accepted.
- Cycles 1..N: pairs are issued. N = 16, or 4 when squaring is enabled and `square`=1.
- The product of a pair issued in cycle t is accumulated at the end of cycle t+MUL_LAT.
- `done`=1 in cycle N+MUL_LAT+1:
  - latency 19 at the default MUL_LAT for a full multiply;
  - latency 7 for a squaring with the feature enabled.
- `busy`=1 in cycles 1..N+MUL_LAT. Exactly one issue occurs per ISSUE cycle, with no stalls; the core accepts every cycle.

## Configuration
- `GF571_MUL_SQUARE_EN` defined:
  - When `square`=1 is sampled, only the diagonal pairs (0,0),(1,1),(2,2),(3,3) are issued. Their offsets are 0, 2, 4, 6.
  - In GF(2) the cross terms A_iB_j ⊕ A_jB_i cancel, so the result is identical to the full multiply.
  - `b` is ignored in this mode, and A is used for both core inputs.
- Undefined: `square` is ignored and all 16 pairs are always issued.

## Structure
- Package `gf571_pkg` holds:
  - the constants LIMB_W=143, NLIMB=4, PAD_W=572, PROD_W=1141, ACC_W=1144;
  - the state enum {IDLE, ISSUE, DRAIN};
  - the 3-bit offset typedef.
- One sub-module, `mult143`, instantiated once as the shared core. Its internal pipeline depth must equal MUL_LAT.

## Test plan
- a=1, b=1 → `d`=1, `done` in cycle 19 (MUL_LAT=2), `busy` high in cycles 1..18.
- a=x^570, b=x^570 → `d`=x^1140 only. This checks the top limb and the maximum offset.
- a = all ones (571 bits), b=x^143 → `d` bits 143..713 set, all other bits zero. This checks limb boundary alignment.
- 1000 random operand pairs, with back-to-back `start` on each `done` cycle → every `d` matches a software carry-less multiply; no idle cycle between operations.
- a = x^300+x+1, square=1:
  - macro defined → `d` = x^600+x^2+1 at cycle 7;
  - macro undefined → the same `d` at cycle 19.
- `rst` asserted in cycle 8 of an operation → `busy`=0, `done`=0 and `d`=0 on the next cycle, with no late `done`. A new `start` with a=b=x+1 → `d`=x^2+1.
